// File: rtl/rptr_fwft_handler.sv
// rptr_fwft_handler: read-side pointer, flag and optional FWFT controller of the dual-clock FIFO.
// Define RPTR_UNDERFLOW_STICKY_EN to hold underflow_o high from the first underflow until reset.
module rptr_fwft_handler #(
    parameter int PTR_WD    = 10,
    parameter int DEPTH     = 1024,
    parameter bit FWFT      = 1'b0,
    parameter int AE_THRESH = 4
) (
    input  logic              r_clk_i,
    input  logic              r_rst_ni,
    input  logic              r_en_i,
    input  logic [PTR_WD:0]   g_wptr_sync_i,
    output logic [PTR_WD:0]   b_rptr_o,
    output logic [PTR_WD:0]   g_rptr_o,
    output logic [PTR_WD-1:0] ram_raddr_o,
    output logic              ram_ren_o,
    output logic              r_valid_o,
    output logic              empty_o,
    output logic              almost_empty_o,
    output logic [PTR_WD:0]   rd_cnt_o,
    output logic              underflow_o
);
    localparam int AW = PTR_WD + 1;
    localparam int AE = (AE_THRESH < DEPTH) ? AE_THRESH : DEPTH - 1;

    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

    state_t state, state_nxt;
    logic [AW-1:0] wbin, b_rptr_nxt, g_rptr_nxt, fill_nxt, cnt_nxt;
    logic mem_empty, empty_nxt, uf;

    for (genvar i = 0; i < AW; i++) begin : g_bin
        assign wbin[i] = ^g_wptr_sync_i[PTR_WD:i];
    end

    assign mem_empty   = (g_rptr_o == g_wptr_sync_i);
    assign uf          = r_en_i & ~r_valid_o;
    assign ram_raddr_o = b_rptr_o[PTR_WD-1:0];

    // A pop request while no word is presented is an underflow, so it also blocks the prefetch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (~mem_empty & ~r_en_i) state_nxt = FETCH;
            FETCH:   state_nxt = VALID;
            VALID:   if (r_en_i & mem_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ram_ren_o = FWFT ? ((state == IDLE) & ~mem_empty & ~r_en_i) | ((state == VALID) & r_en_i & ~mem_empty)
                         : r_en_i & ~empty_o;
        r_valid_o = FWFT ? (state == VALID) : ~empty_o;
    end

    always_comb begin
        b_rptr_nxt = b_rptr_o + AW'(ram_ren_o);
        g_rptr_nxt = b_rptr_nxt ^ (b_rptr_nxt >> 1);
        fill_nxt   = wbin - b_rptr_nxt;
        cnt_nxt    = FWFT ? fill_nxt + AW'(state_nxt == VALID) + AW'(state_nxt == FETCH) : fill_nxt;
        empty_nxt  = FWFT ? (state_nxt != VALID) : (g_rptr_nxt == g_wptr_sync_i);
    end

    always_ff @(posedge r_clk_i or negedge r_rst_ni) begin
        if (!r_rst_ni) begin
            state          <= IDLE;
            b_rptr_o       <= '0;
            g_rptr_o       <= '0;
            rd_cnt_o       <= '0;
            empty_o        <= 1'b1;
            almost_empty_o <= 1'b1;
            underflow_o    <= 1'b0;
        end else begin
            state          <= FWFT ? state_nxt : IDLE;
            b_rptr_o       <= b_rptr_nxt;
            g_rptr_o       <= g_rptr_nxt;
            rd_cnt_o       <= cnt_nxt;
            empty_o        <= empty_nxt;
            almost_empty_o <= cnt_nxt <= AW'(AE);
`ifdef RPTR_UNDERFLOW_STICKY_EN
            underflow_o    <= underflow_o | uf;
`else
            underflow_o    <= uf;
`endif
        end
    end
endmodule
